// File: rtl/home_inventory_pkg.sv
// Shared constants for the multi-channel home-inventory Wishbone register block:
// register map, identification words, IRQ bit positions and the byte-lane merge helper.
package home_inventory_pkg;

  localparam logic [31:0] HI_ID      = 32'h4849_4348;
  localparam logic [31:0] HI_VERSION = 32'h0000_0002;

  localparam logic [11:0] ADR_ID         = 12'h000;
  localparam logic [11:0] ADR_VERSION    = 12'h004;
  localparam logic [11:0] ADR_CTRL       = 12'h100;
  localparam logic [11:0] ADR_IRQ_EN     = 12'h104;
  localparam logic [11:0] ADR_STATUS     = 12'h108;
  localparam logic [11:0] ADR_IRQ_ST     = 12'h10C;
  localparam logic [11:0] ADR_ADC_CFG    = 12'h200;
  localparam logic [11:0] ADR_ADC_CMD    = 12'h204;
  localparam logic [11:0] ADR_SNAP_SEQ   = 12'h208;
  localparam logic [11:0] ADR_RAW_BASE   = 12'h210;
  localparam logic [11:0] ADR_TARE_BASE  = 12'h300;
  localparam logic [11:0] ADR_SCALE_BASE = 12'h320;
  localparam logic [11:0] ADR_EVT_BASE   = 12'h400;

  localparam int IRQ_SNAP = 0;
  localparam int IRQ_EVT  = 1;
  localparam int IRQ_OVF  = 2;

  localparam logic [31:0] SCALE_RESET = 32'h0001_0000;

  function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/hi_evt_counter.sv
// One saturating event counter. o_ovf flags the pulse that reaches the ceiling
// as well as any pulse arriving while already saturated; a clear swallows a same-edge pulse.
module hi_evt_counter #(
  parameter int EVT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pulse,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [EVT_W-1:0] o_cnt,
  output logic             o_evt,
  output logic             o_ovf
);

  localparam logic [EVT_W-1:0] MAX = '1;

  logic [EVT_W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_evt = i_pulse & i_en;
  assign o_ovf = o_evt & ~i_clr & ((r_cnt == MAX) || (r_cnt == MAX - 1'b1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (o_evt && (r_cnt != MAX))
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/home_inventory_wb_mc.sv
// Wishbone register block for NUM_CH measurement channels: live ADC capture with atomic
// snapshot, per-channel tare/scale, saturating event counters and a W1C level interrupt.
module home_inventory_wb_mc
  import home_inventory_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int RAW_W  = 24,
  parameter int EVT_W  = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  input  logic [7:0]            core_status,
  input  logic                  adc_valid_i,
  input  logic [2:0]            adc_ch_i,
  input  logic [RAW_W-1:0]      adc_data_i,
  input  logic [NUM_CH-1:0]     evt_pulse_i,
  output logic                  ctrl_enable,
  output logic                  ctrl_start,
  output logic [2:0]            irq_en,
  output logic                  irq_o,
  output logic [32*NUM_CH-1:0]  tare_o,
  output logic [32*NUM_CH-1:0]  scale_o
);

  logic                    r_ack, r_enable, r_start;
  logic [31:0]             r_dat;
  logic [2:0]              r_irq_en, r_irq_st;
  logic [3:0]              r_active;
  logic [15:0]             r_seq;
  logic signed [RAW_W-1:0] r_live   [NUM_CH];
  logic [31:0]             r_shadow [NUM_CH];
  logic [31:0]             r_tare   [NUM_CH];
  logic [31:0]             r_scale  [NUM_CH];

  logic              w_acc, w_wr, w_snap, w_clr_evt, w_smp_ok;
  logic [11:0]       w_off;
  logic [2:0]        w_idx, w_raw_idx, w_irq_set, w_irq_clr;
  logic              w_idx_ok, w_raw_hit, w_tare_hit, w_scale_hit, w_evt_hit;
  logic [NUM_CH-1:0] w_evt, w_ovf;
  logic [EVT_W-1:0]  w_cnt [NUM_CH];
  logic [31:0]       w_rdata;
  logic              w_unused;

  // Only the 4 KiB window below bit 12 is decoded; the upstream slave decode selects the block.
  assign w_off     = {wbs_adr_i[11:2], 2'b00};
  assign w_unused  = ^{wbs_adr_i[31:12], wbs_adr_i[1:0]};
  assign w_idx     = wbs_adr_i[4:2];
  assign w_raw_idx = wbs_adr_i[4:2] - 3'd4;
  assign w_idx_ok  = int'(w_idx) < NUM_CH;

  assign w_raw_hit   = (w_off >= ADR_RAW_BASE) && (w_off < ADR_RAW_BASE + 12'h020) &&
                       (int'(w_raw_idx) < NUM_CH);
  assign w_tare_hit  = (w_off[11:5] == ADR_TARE_BASE[11:5])  && w_idx_ok;
  assign w_scale_hit = (w_off[11:5] == ADR_SCALE_BASE[11:5]) && w_idx_ok;
  assign w_evt_hit   = (w_off[11:5] == ADR_EVT_BASE[11:5])   && w_idx_ok;

  assign w_acc     = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr      = w_acc & wbs_we_i;
  assign w_snap    = w_wr && (w_off == ADR_ADC_CMD) && wbs_sel_i[0] && wbs_dat_i[0];
  assign w_clr_evt = w_wr && (w_off == ADR_ADC_CMD) && wbs_sel_i[0] && wbs_dat_i[1];
  assign w_smp_ok  = adc_valid_i && (int'(adc_ch_i) < NUM_CH) && ({1'b0, adc_ch_i} < r_active);

  assign w_irq_set = {|w_ovf, |w_evt, w_snap};
  assign w_irq_clr = (w_wr && (w_off == ADR_IRQ_ST) && wbs_sel_i[0]) ? wbs_dat_i[2:0] : 3'd0;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    hi_evt_counter #(.EVT_W(EVT_W)) u_cnt (
      .i_clk   (wb_clk_i),
      .i_rst_n (wb_rst_ni),
      .i_pulse (evt_pulse_i[n]),
      .i_en    (r_enable),
      .i_clr   (w_clr_evt),
      .o_cnt   (w_cnt[n]),
      .o_evt   (w_evt[n]),
      .o_ovf   (w_ovf[n])
    );
    assign tare_o[32*n +: 32]  = r_tare[n];
    assign scale_o[32*n +: 32] = r_scale[n];
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      ADR_ID:       w_rdata = HI_ID;
      ADR_VERSION:  w_rdata = HI_VERSION;
      ADR_CTRL:     w_rdata = {31'd0, r_enable};
      ADR_IRQ_EN:   w_rdata = {29'd0, r_irq_en};
      ADR_STATUS:   w_rdata = {24'd0, core_status};
      ADR_IRQ_ST:   w_rdata = {29'd0, r_irq_st};
      ADR_ADC_CFG:  w_rdata = {28'd0, r_active};
      ADR_SNAP_SEQ: w_rdata = {16'd0, r_seq};
      default:      w_rdata = '0;
    endcase
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_raw_hit   && (w_raw_idx == 3'(n))) w_rdata = r_shadow[n];
      if (w_tare_hit  && (w_idx == 3'(n)))     w_rdata = r_tare[n];
      if (w_scale_hit && (w_idx == 3'(n)))     w_rdata = r_scale[n];
      if (w_evt_hit   && (w_idx == 3'(n)))     w_rdata = 32'(w_cnt[n]);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_enable <= 1'b0;
      r_start  <= 1'b0;
      r_irq_en <= '0;
      r_irq_st <= '0;
      r_active <= 4'(NUM_CH);
      r_seq    <= '0;
    end else begin
      r_ack   <= w_acc;
      r_start <= w_wr && (w_off == ADR_CTRL) && wbs_sel_i[0] && wbs_dat_i[1];
      if (w_acc) r_dat <= w_rdata;
      if (w_wr && (w_off == ADR_CTRL)    && wbs_sel_i[0]) r_enable <= wbs_dat_i[0];
      if (w_wr && (w_off == ADR_IRQ_EN)  && wbs_sel_i[0]) r_irq_en <= wbs_dat_i[2:0];
      if (w_wr && (w_off == ADR_ADC_CFG) && wbs_sel_i[0]) r_active <= wbs_dat_i[3:0];
      if (w_snap) r_seq <= r_seq + 16'd1;
      // A set on the same edge as its W1C clear wins.
      r_irq_st <= (r_irq_st & ~w_irq_clr) | w_irq_set;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      for (int n = 0; n < NUM_CH; n++) begin
        r_live[n]   <= '0;
        r_shadow[n] <= '0;
        r_tare[n]   <= '0;
        r_scale[n]  <= SCALE_RESET;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (w_smp_ok && (adc_ch_i == 3'(n))) r_live[n] <= adc_data_i;
        // Shadow takes the pre-edge live value, so a same-edge sample is not included.
        if (w_snap) r_shadow[n] <= 32'(r_live[n]);
        if (w_wr && w_tare_hit && (w_idx == 3'(n)))
          r_tare[n] <= apply_sel(r_tare[n], wbs_dat_i, wbs_sel_i);
        if (w_wr && w_scale_hit && (w_idx == 3'(n)))
          r_scale[n] <= apply_sel(r_scale[n], wbs_dat_i, wbs_sel_i);
      end
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign ctrl_enable = r_enable;
  assign ctrl_start  = r_start;
  assign irq_en      = r_irq_en;
  assign irq_o       = |(r_irq_st & r_irq_en);

endmodule

// File: tb/tb_home_inventory_wb_mc.sv
// Self-checking bench for home_inventory_wb_mc: directed scenarios plus randomized traffic
// compared against a register-map level reference model.
module tb_home_inventory_wb_mc;

  localparam int NUM_CH = 4;
  localparam int RAW_W  = 24;
  localparam int EVT_W  = 4;
  localparam int MAXC   = (1 << EVT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 stb, cyc, we;
  logic [3:0]           sel;
  logic [31:0]          adr, dat_w;
  logic                 ack;
  logic [31:0]          dat_r;
  logic [7:0]           core_status;
  logic                 adc_valid;
  logic [2:0]           adc_ch;
  logic [RAW_W-1:0]     adc_data;
  logic [NUM_CH-1:0]    evt_pulse;
  logic                 ctrl_enable, ctrl_start, irq_o;
  logic [2:0]           irq_en;
  logic [32*NUM_CH-1:0] tare_o, scale_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [RAW_W-1:0] m_live   [NUM_CH];
  logic [31:0]      m_shadow [NUM_CH];
  logic [31:0]      m_tare   [NUM_CH];
  logic [31:0]      m_scale  [NUM_CH];
  int               m_cnt    [NUM_CH];
  logic [2:0]       m_irq_st, m_irq_en;
  logic             m_enable;
  int               m_active, m_seq;

  always #5 clk = ~clk;

  home_inventory_wb_mc #(.NUM_CH(NUM_CH), .RAW_W(RAW_W), .EVT_W(EVT_W)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .core_status(core_status), .adc_valid_i(adc_valid), .adc_ch_i(adc_ch),
    .adc_data_i(adc_data), .evt_pulse_i(evt_pulse),
    .ctrl_enable(ctrl_enable), .ctrl_start(ctrl_start), .irq_en(irq_en), .irq_o(irq_o),
    .tare_o(tare_o), .scale_o(scale_o)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] sext(input logic [RAW_W-1:0] v);
    longint x;
    x = longint'(v);
    if (x >= (64'sd1 <<< (RAW_W - 1))) x = x - (64'sd1 <<< RAW_W);
    return 32'(x);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a)
      32'h000: return 32'h4849_4348;
      32'h004: return 32'h0000_0002;
      32'h100: return {31'd0, m_enable};
      32'h104: return {29'd0, m_irq_en};
      32'h108: return {24'd0, core_status};
      32'h10C: return {29'd0, m_irq_st};
      32'h200: return 32'(m_active);
      32'h208: return 32'(m_seq % 65536);
      default: ;
    endcase
    for (int n = 0; n < NUM_CH; n++) begin
      if (a == 32'(32'h210 + 4*n)) return m_shadow[n];
      if (a == 32'(32'h300 + 4*n)) return m_tare[n];
      if (a == 32'(32'h320 + 4*n)) return m_scale[n];
      if (a == 32'(32'h400 + 4*n)) return 32'(m_cnt[n]);
    end
    return 32'h0;
  endfunction

  task automatic m_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      m_live[n] = '0; m_shadow[n] = '0; m_tare[n] = '0;
      m_scale[n] = 32'h0001_0000; m_cnt[n] = 0;
    end
    m_irq_st = '0; m_irq_en = '0; m_enable = 1'b0; m_active = NUM_CH; m_seq = 0;
  endtask

  task automatic m_snapshot();
    for (int n = 0; n < NUM_CH; n++) m_shadow[n] = sext(m_live[n]);
    m_seq = m_seq + 1;
    m_irq_st[0] = 1'b1;
  endtask

  task automatic m_sample(input int ch, input logic [RAW_W-1:0] d);
    if (ch < NUM_CH && ch < m_active) m_live[ch] = d;
  endtask

  task automatic m_pulse(input logic [NUM_CH-1:0] mask, input bit cleared);
    if (!m_enable) return;
    for (int n = 0; n < NUM_CH; n++) begin
      if (!mask[n]) continue;
      m_irq_st[1] = 1'b1;
      if (cleared) continue;
      if (m_cnt[n] == MAXC) m_irq_st[2] = 1'b1;
      else begin
        m_cnt[n] = m_cnt[n] + 1;
        if (m_cnt[n] == MAXC) m_irq_st[2] = 1'b1;
      end
    end
  endtask

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a == 32'h100 && s[0]) m_enable = d[0];
    if (a == 32'h104 && s[0]) m_irq_en = d[2:0];
    if (a == 32'h10C && s[0]) m_irq_st = m_irq_st & ~d[2:0];
    if (a == 32'h200 && s[0]) m_active = int'(d[3:0]);
    if (a == 32'h204 && s[0]) begin
      if (d[0]) m_snapshot();
      if (d[1]) for (int n = 0; n < NUM_CH; n++) m_cnt[n] = 0;
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (a == 32'(32'h300 + 4*n)) m_tare[n]  = merge(m_tare[n], d, s);
      if (a == 32'(32'h320 + 4*n)) m_scale[n] = merge(m_scale[n], d, s);
    end
  endtask

  // ---------------- bus / stimulus drivers ----------------
  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input bit side_adc, input int side_ch,
                     input logic [RAW_W-1:0] side_d, input logic [NUM_CH-1:0] side_pulse,
                     output logic [31:0] rdata, output int cycles);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    if (side_adc) begin adc_valid = 1'b1; adc_ch = 3'(side_ch); adc_data = side_d; end
    evt_pulse = side_pulse;
    @(negedge clk);
    adc_valid = 1'b0; evt_pulse = '0;
    cycles = 1;
    while (!ack && cycles < 8) begin @(negedge clk); cycles++; end
    rdata = dat_r;
    if (!ack) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout addr=%h: no ack after %0d cycles", a, cycles);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd_unused; int c;
    bus(1'b1, a, d, s, 1'b0, 0, '0, '0, rd_unused, c);
    m_write(a, d, s);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    int c;
    bus(1'b0, a, 32'h0, 4'hF, 1'b0, 0, '0, '0, v, c);
  endtask

  task automatic drive_sample(input int ch, input logic [RAW_W-1:0] d);
    @(negedge clk);
    adc_valid = 1'b1; adc_ch = 3'(ch); adc_data = d;
    @(negedge clk);
    adc_valid = 1'b0;
    m_sample(ch, d);
  endtask

  task automatic drive_pulse(input logic [NUM_CH-1:0] mask);
    @(negedge clk);
    evt_pulse = mask;
    @(negedge clk);
    evt_pulse = '0;
    m_pulse(mask, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] addrs [6];
    addrs = '{32'h000, 32'h004, 32'h32C, 32'h200, 32'h10C, 32'h208};
    rst_n = 1'b0; cyc = 0; stb = 0; we = 0; sel = 4'hF; adr = '0; dat_w = '0;
    adc_valid = 0; adc_ch = '0; adc_data = '0; evt_pulse = '0; core_status = 8'h5A;
    m_reset();
    repeat (3) @(negedge clk);
    cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_drops_ack: ack=%b want 0", ack); end
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ack, ctrl_enable, ctrl_start, irq_en, irq_o} !== 7'd0 || dat_r !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: ack=%b en=%b start=%b irq_en=%b irq=%b dat=%h want all 0",
               ack, ctrl_enable, ctrl_start, irq_en, irq_o, dat_r);
    end
    n_cmp++;
    if (tare_o !== '0 || scale_o !== {NUM_CH{32'h0001_0000}}) begin
      n_bad++; $display("FAIL reset_tare_scale: tare=%h scale=%h", tare_o, scale_o);
    end
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i], v);
      n_cmp++;
      if (v !== model_read(addrs[i])) begin
        n_bad++; $display("FAIL reset_read[%h]: got %h want %h", addrs[i], v, model_read(addrs[i]));
      end
    end
    rd(32'h000, v);
    n_cmp++;
    if (v !== 32'h4849_4348) begin n_bad++; $display("FAIL id_const: got %h want 48494348", v); end
  endtask

  task automatic test_capture_snapshot();
    logic [31:0] v;
    drive_sample(2, 24'h800001);
    wr(32'h204, 32'h1, 4'hF);
    rd(32'h218, v);
    n_cmp++;
    if (v !== 32'hFF80_0001 || v !== model_read(32'h218)) begin
      n_bad++; $display("FAIL raw_ch2: got %h want ff800001", v);
    end
    rd(32'h208, v);
    n_cmp++;
    if (v !== model_read(32'h208)) begin n_bad++; $display("FAIL snap_seq: got %h want %h", v, model_read(32'h208)); end
    wr(32'h104, 32'h1, 4'hF);
    n_cmp++;
    if (irq_o !== 1'b1) begin n_bad++; $display("FAIL irq_snap_set: irq_o=%b want 1", irq_o); end
    wr(32'h10C, 32'h1, 4'hF);
    n_cmp++;
    if (irq_o !== 1'b0) begin n_bad++; $display("FAIL irq_snap_w1c: irq_o=%b want 0", irq_o); end
  endtask

  task automatic test_capture_gating();
    logic [31:0] v;
    wr(32'h200, 32'h2, 4'hF);
    drive_sample(3, 24'h123456);
    drive_sample(1, 24'h00ABCD);
    wr(32'h204, 32'h1, 4'hF);
    rd(32'h21C, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL gated_ch3: got %h want 0", v); end
    rd(32'h214, v);
    n_cmp++;
    if (v !== model_read(32'h214)) begin n_bad++; $display("FAIL open_ch1: got %h want %h", v, model_read(32'h214)); end
    wr(32'h200, 32'h4, 4'hF);
  endtask

  task automatic test_saturation();
    logic [31:0] v; logic [31:0] rd_unused; int c;
    wr(32'h100, 32'h1, 4'hF);
    for (int i = 0; i < 20; i++) drive_pulse(4'b0001);
    rd(32'h400, v);
    n_cmp++;
    if (v !== 32'd15) begin n_bad++; $display("FAIL sat_count: got %0d want 15", v); end
    rd(32'h10C, v);
    n_cmp++;
    if (v[2] !== 1'b1 || v !== model_read(32'h10C)) begin
      n_bad++; $display("FAIL sat_ovf: irq_status=%h want %h", v, model_read(32'h10C));
    end
    bus(1'b1, 32'h204, 32'h2, 4'hF, 1'b0, 0, '0, 4'b0001, rd_unused, c);
    m_write(32'h204, 32'h2, 4'hF);
    m_pulse(4'b0001, 1'b1);
    rd(32'h400, v);
    n_cmp++;
    if (v !== 32'd0) begin n_bad++; $display("FAIL clear_with_pulse: got %0d want 0", v); end
    wr(32'h10C, 32'h7, 4'hF);
  endtask

  task automatic test_byte_strobes();
    logic [31:0] v;
    wr(32'h304, 32'h0000_BEEF, 4'b0011);
    wr(32'h304, 32'hDEAD_0000, 4'b1100);
    rd(32'h304, v);
    n_cmp++;
    if (v !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL tare_bytes: got %h want deadbeef", v); end
    n_cmp++;
    if (tare_o[63:32] !== m_tare[1]) begin
      n_bad++; $display("FAIL tare_o_ch1: got %h want %h", tare_o[63:32], m_tare[1]);
    end
  endtask

  task automatic test_pulse_unmapped();
    logic [31:0] v; int c;
    wr(32'h100, 32'h2, 4'hF);
    n_cmp++;
    if (ctrl_start !== 1'b1) begin n_bad++; $display("FAIL start_high: ctrl_start=%b want 1", ctrl_start); end
    @(negedge clk);
    n_cmp++;
    if (ctrl_start !== 1'b0) begin n_bad++; $display("FAIL start_width: ctrl_start=%b want 0", ctrl_start); end
    rd(32'h100, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL ctrl_read: got %h want 0", v); end
    wr(32'h7F0, 32'hFFFF_FFFF, 4'hF);
    wr(32'h000, 32'h1234_5678, 4'hF);
    bus(1'b0, 32'h41C, 32'h0, 4'hF, 1'b0, 0, '0, '0, v, c);
    n_cmp++;
    if (v !== 32'h0 || c !== 1) begin n_bad++; $display("FAIL unmapped_41c: got %h in %0d cycles want 0 in 1", v, c); end
    bus(1'b0, 32'h7F0, 32'h0, 4'hF, 1'b0, 0, '0, '0, v, c);
    n_cmp++;
    if (v !== 32'h0 || c !== 1) begin n_bad++; $display("FAIL unmapped_7f0: got %h in %0d cycles want 0 in 1", v, c); end
    rd(32'h000, v);
    n_cmp++;
    if (v !== 32'h4849_4348) begin n_bad++; $display("FAIL id_ro: got %h want 48494348", v); end
  endtask

  task automatic test_back_to_back();
    bit exp;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h004; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = (i % 2 == 0);
      n_cmp++;
      if (ack !== exp || (exp && dat_r !== 32'h2)) begin
        n_bad++; $display("FAIL b2b_cycle%0d: ack=%b dat=%h want ack=%b dat=2", i, ack, dat_r, exp);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] v, a, d, rd_unused;
    logic [31:0] fixed [9];
    int op, ch, c;
    bit side;
    logic [RAW_W-1:0] sd;
    fixed = '{32'h000, 32'h004, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h200, 32'h204, 32'h208};
    core_status = 8'($urandom);
    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 7);
      case (op)
        0: begin
          a = ($urandom_range(0, 1) ? 32'h300 : 32'h320) + 32'(4 * $urandom_range(0, 7));
          d = $urandom;
          wr(a, d, 4'($urandom));
        end
        1: drive_sample($urandom_range(0, 7), RAW_W'($urandom));
        2: begin
          side = 1'($urandom); ch = $urandom_range(0, 3); sd = RAW_W'($urandom);
          bus(1'b1, 32'h204, 32'h1, 4'hF, side, ch, sd, '0, rd_unused, c);
          m_write(32'h204, 32'h1, 4'hF);
          if (side) m_sample(ch, sd);
        end
        3: drive_pulse(NUM_CH'($urandom));
        4: wr(32'h100, 32'($urandom_range(0, 3)), 4'hF);
        5: begin
          case ($urandom_range(0, 3))
            0: a = fixed[$urandom_range(0, 8)];
            1: a = 32'h210 + 32'(4 * $urandom_range(0, 7));
            2: a = 32'h300 + 32'(4 * $urandom_range(0, 15));
            default: a = 32'h400 + 32'(4 * $urandom_range(0, 7));
          endcase
          rd(a, v);
          n_cmp++;
          if (v !== model_read(a)) begin
            n_bad++; $display("FAIL rand_read[%h]: got %h want %h", a, v, model_read(a));
          end
        end
        6: wr(($urandom_range(0, 1) ? 32'h10C : 32'h104), 32'($urandom_range(0, 7)), 4'hF);
        default: wr(32'h200, 32'($urandom_range(0, 8)), 4'hF);
      endcase
      n_cmp++;
      if (irq_o !== |(m_irq_st & m_irq_en) || ctrl_enable !== m_enable || irq_en !== m_irq_en) begin
        n_bad++; $display("FAIL rand_outputs it=%0d: irq=%b en=%b irq_en=%b want %b %b %b",
                          it, irq_o, ctrl_enable, irq_en, |(m_irq_st & m_irq_en), m_enable, m_irq_en);
      end
    end
    for (int n = 0; n < 8; n++) begin
      a = 32'h210 + 32'(4 * n);
      rd(a, v);
      n_cmp++;
      if (v !== model_read(a)) begin n_bad++; $display("FAIL sweep_raw[%0d]: got %h want %h", n, v, model_read(a)); end
      a = 32'h400 + 32'(4 * n);
      rd(a, v);
      n_cmp++;
      if (v !== model_read(a)) begin n_bad++; $display("FAIL sweep_evt[%0d]: got %h want %h", n, v, model_read(a)); end
    end
    for (int n = 0; n < NUM_CH; n++) begin
      n_cmp++;
      if (tare_o[32*n +: 32] !== m_tare[n] || scale_o[32*n +: 32] !== m_scale[n]) begin
        n_bad++; $display("FAIL sweep_ports[%0d]: tare=%h scale=%h want %h %h",
                          n, tare_o[32*n +: 32], scale_o[32*n +: 32], m_tare[n], m_scale[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture_snapshot();
    test_capture_gating();
    test_saturation();
    test_byte_strobes();
    test_pulse_unmapped();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/home_inventory_wb_mc.md
# home_inventory_wb_mc

Parametrised multi-channel successor of the home-inventory Wishbone register block. It sits between the Caravel Wishbone slave port and the measurement core. It provides:
- NUM_CH channels of live ADC capture with atomic snapshot into readback registers;
- per-channel tare/scale calibration registers;
- saturating per-channel event counters;
- a W1C interrupt status register driving a single level IRQ.

VERSION reads 0x0000_0002.

## Interface
Parameters:
- NUM_CH, 4, channel count, legal range 1..8.
- RAW_W, 24, ADC sample width. Sign-extended to 32 bits on readback.
- EVT_W, 16, event counter width, range 1..32. Zero-extended on readback.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  synchronous, active-low reset, sampled on rising wb_clk_i.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone classic strobe, cycle and write enable.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i, wbs_dat_i  in  32  address and write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  registered read data.
- core_status  in  8  passthrough to STATUS[7:0].
- adc_valid_i  in  1  live sample strobe.
- adc_ch_i  in  3  sample channel index.
- adc_data_i  in  RAW_W  sample value, two's complement.
- evt_pulse_i  in  NUM_CH  one-cycle event pulses, one bit per channel.
- ctrl_enable  out  1  CTRL[0].
- ctrl_start  out  1  one-cycle pulse.
- irq_en  out  3  IRQ_EN[2:0].
- irq_o  out  1  |(IRQ_STATUS & IRQ_EN).
- tare_o  out  32*NUM_CH  flattened; channel n is bits [32n+31:32n].
- scale_o  out  32*NUM_CH  flattened, same packing as tare_o.

## Operation
Address map (byte addresses; adr[1:0] ignored):

| Reg | Address | Access | Reset / content |
|---|---|---|---|
| ID | 0x000 | RO | 0x4849_4348 |
| VERSION | 0x004 | RO | 0x0000_0002 |
| CTRL | 0x100 | RW | [0] ENABLE sticky; [1] START write-1-pulse, reads 0 |
| IRQ_EN | 0x104 | RW | [2:0] |
| STATUS | 0x108 | RO | core_status |
| IRQ_STATUS | 0x10C | W1C | [0] SNAP, [1] EVT, [2] OVF |
| ADC_CFG | 0x200 | RW | [3:0] ACTIVE_CH, reset value NUM_CH |
| ADC_CMD | 0x204 | write-1-pulse, reads 0 | [0] SNAPSHOT, [1] CLEAR_EVT |
| SNAP_SEQ | 0x208 | RO | 16-bit wrapping snapshot count |
| ADC_RAW_CHn | 0x210+4n | RO | shadow sample |
| TARE_CHn | 0x300+4n | RW | reset 0 |
| SCALE_CHn | 0x320+4n | RW | reset 0x0001_0000 |
| EVT_COUNT_CHn | 0x400+4n | RO | event counter |

Addressing rules:
- For n >= NUM_CH, and for any unmapped address, reads return 0 and writes are ignored. The access is still acked.
- All RW registers honour wbs_sel_i per byte.
- Writes to RO registers are ignored.

Live capture:
- A sample is accepted on adc_valid_i when adc_ch_i < NUM_CH and adc_ch_i < ACTIVE_CH. Accepted samples write live[adc_ch_i]. Other samples are dropped.
- Live registers are not bus-visible.

SNAPSHOT (write 1 to ADC_CMD[0]), all on the accepting edge:
- Every shadow[n] is loaded from live[n], sign-extended to 32 bits.
- SNAP_SEQ increments.
- IRQ_STATUS.SNAP is set.
- If a sample is accepted on the same edge, the shadow takes the old live value.

Event counters:
- evt_pulse_i[n] increments cnt[n] only while ctrl_enable=1.
- Each accepted pulse sets EVT.
- Counters saturate at 2^EVT_W-1. The increment that reaches saturation sets OVF. Pulses at saturation leave the count unchanged and set OVF again.

CLEAR_EVT zeroes all counters. A pulse on the same edge is lost, so the count reads 0.

IRQ_STATUS rules:
- Writing 1 clears a bit.
- If a set condition and a clear occur on the same edge, the set wins.
- irq_o is combinational from registered state.

## Timing
- Accept edge: rising edge where wbs_cyc_i & wbs_stb_i & !wbs_ack_o.
- wbs_ack_o is high for exactly the one cycle after the accept edge. wbs_dat_o is valid in that same cycle.
- Back-to-back requests therefore ack at most every other cycle.
- Register writes and command side effects take effect at the accept edge, so they are visible when ack rises.
- ctrl_start is high for exactly the cycle following the accept edge of a CTRL write with bit1=1 and sel[0]=1.
- Reading a register in the cycle after a write returns the new value.
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0.
  - ctrl_enable=0, ctrl_start=0, irq_en=0, irq_o=0.
  - All live and shadow registers, all counters, SNAP_SEQ and IRQ_STATUS are 0.
  - tare_o is 0. scale_o is 0x0001_0000 per channel.
- Reset asserted mid-transaction drops the pending ack. The master must retry.

## Structure
- Package home_inventory_pkg holds:
  - register address localparams;
  - ID and VERSION constants;
  - IRQ bit indices;
  - SCALE_RESET.
- One sub-module, hi_evt_counter: one saturating counter with enable, clear and OVF output, instantiated NUM_CH times via generate.

## Test plan
- Reset read sweep: ID → 0x48494348, VERSION → 2, SCALE_CH3 → 0x00010000, ADC_CFG → 4, IRQ_STATUS → 0, irq_o=0.
- Capture and snapshot:
  1. Drive ch2 with adc_data=0x800001.
  2. Write SNAPSHOT.
  3. ADC_RAW_CH2 → 0xFF800001 and SNAP_SEQ → 1.
  4. With IRQ_EN=1, irq_o=1; W1C of 0x1 drops it to 0.
- Capture gating: ACTIVE_CH=2; a sample on ch3 then SNAPSHOT → RAW_CH3 remains 0.
- Counter saturation, with EVT_W=4 and ENABLE=1:
  1. 20 pulses on ch0 → EVT_COUNT_CH0=15 and OVF=1.
  2. CLEAR_EVT issued on the same edge as a pulse → count 0.
- Byte strobes: write TARE_CH1 with 0xBEEF, sel=0011, then 0xDEAD0000, sel=1100 → reads 0xDEADBEEF, and tare_o[63:32] matches.
- Pulse and unmapped access:
  - CTRL write 0x2 → ctrl_start high exactly one cycle; CTRL reads 0.
  - Reads of 0x41C (with NUM_CH=4) and 0x7F0 → 0, each acked in one cycle.
